// File: rtl/r88_pkg.sv
// rtl/r88_pkg.sv - shared state codes, interrupt causes and vector addresses
package r88_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_BOOT     = 3'd1;
  localparam logic [2:0] ST_PUSH_PCH = 3'd2;
  localparam logic [2:0] ST_PUSH_PCL = 3'd3;
  localparam logic [2:0] ST_PUSH_FLG = 3'd4;
  localparam logic [2:0] ST_VEC_LO   = 3'd5;
  localparam logic [2:0] ST_VEC_HI   = 3'd6;
  localparam logic [2:0] ST_DONE     = 3'd7;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_RESET = 2'd1;
  localparam logic [1:0] CAUSE_NMI   = 2'd2;
  localparam logic [1:0] CAUSE_IRQ   = 2'd3;

  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

  function automatic logic [15:0] vecBase(input logic [1:0] cause);
    case (cause)
      CAUSE_NMI: vecBase = VEC_NMI;
      CAUSE_IRQ: vecBase = VEC_IRQ;
      default:   vecBase = VEC_RESET;
    endcase
  endfunction

endpackage

// File: rtl/r88_edge_det.sv
// rtl/r88_edge_det.sv - rising-edge detector against a registered previous sample
module r88_edge_det (
  input  logic clk,
  input  logic rstN,
  input  logic sig,
  output logic rise
);

  logic prevSig;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) prevSig <= 1'b0;
    else       prevSig <= sig;
  end

  assign rise = sig & ~prevSig;

endmodule

// File: rtl/r88_int_seq.sv
// rtl/r88_int_seq.sv - reset/NMI/IRQ entry sequencer: stack pushes and vector fetch
module r88_int_seq
  import r88_pkg::*;
(
  input  logic        sysClock,
  input  logic        sysResetN,
  input  logic        resetReq,
  input  logic        nmiReq,
  input  logic        irq,
  input  logic        irqEn,
  input  logic        instrBoundary,
  input  logic        busAck,
  output logic        busReq,
  output logic        busWrite,
  output logic [2:0]  seqStep,
  output logic [15:0] vecAddr,
  output logic        haltDecoder,
  output logic        loadPCLow,
  output logic        loadPCHigh,
  output logic        clearIrqEn,
  output logic        intDone,
  output logic [1:0]  intCause
);

  logic [2:0] state, stateNext;
  logic [1:0] cause, causeNext;
  logic       nmiPending, nmiRise, nmiTake;

  r88_edge_det uNmiEdge (
    .clk  (sysClock),
    .rstN (sysResetN),
    .sig  (nmiReq),
    .rise (nmiRise)
  );

  always_comb begin
    stateNext = state;
    causeNext = cause;
    nmiTake   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (instrBoundary) begin
          if (nmiPending) begin
            stateNext = ST_PUSH_PCH;
            causeNext = CAUSE_NMI;
            nmiTake   = 1'b1;
          end else if (irq && irqEn) begin
            stateNext = ST_PUSH_PCH;
            causeNext = CAUSE_IRQ;
          end
        end
      end
      ST_BOOT:     stateNext = ST_VEC_LO;
      ST_PUSH_PCH: if (busAck) stateNext = ST_PUSH_PCL;
      ST_PUSH_PCL: if (busAck) stateNext = ST_PUSH_FLG;
      ST_PUSH_FLG: if (busAck) stateNext = ST_VEC_LO;
      ST_VEC_LO:   if (busAck) stateNext = ST_VEC_HI;
      ST_VEC_HI:   if (busAck) stateNext = ST_DONE;
      ST_DONE: begin
        stateNext = ST_IDLE;
        causeNext = CAUSE_NONE;
      end
      default:     stateNext = ST_IDLE;
    endcase
    // Soft reset overrides everything, including a bus step completing this cycle.
    if (resetReq) begin
      stateNext = ST_VEC_LO;
      causeNext = CAUSE_RESET;
      nmiTake   = 1'b1;
    end
  end

  always_ff @(posedge sysClock or negedge sysResetN) begin
    if (!sysResetN) begin
      state      <= ST_BOOT;
      cause      <= CAUSE_RESET;
      nmiPending <= 1'b0;
    end else begin
      state      <= stateNext;
      cause      <= causeNext;
      // A fresh edge wins over the clear so an NMI arriving at entry is not lost.
      nmiPending <= nmiRise | (nmiPending & ~nmiTake);
    end
  end

  always_comb begin
    busReq   = 1'b0;
    busWrite = 1'b0;
    vecAddr  = 16'h0000;
    case (state)
      ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_FLG: begin
        busReq   = 1'b1;
        busWrite = 1'b1;
      end
      ST_VEC_LO: begin
        busReq  = 1'b1;
        vecAddr = vecBase(cause);
      end
      ST_VEC_HI: begin
        busReq  = 1'b1;
        vecAddr = vecBase(cause) + 16'd1;
      end
      default: ;
    endcase
  end

  assign seqStep     = state;
  assign intCause    = cause;
  assign haltDecoder = (state != ST_IDLE);
  assign loadPCLow   = (state == ST_VEC_LO) && busAck && !resetReq;
  assign loadPCHigh  = (state == ST_VEC_HI) && busAck && !resetReq;
  assign intDone     = (state == ST_DONE);
  assign clearIrqEn  = (state == ST_DONE);

endmodule

// File: tb/tb_r88_int_seq.sv
// tb/tb_r88_int_seq.sv - scoreboard bench for the interrupt entry sequencer
module tb_r88_int_seq;

  logic        sysClock = 1'b0;
  logic        sysResetN, resetReq, nmiReq, irq, irqEn, instrBoundary, busAck;
  logic        busReq, busWrite, haltDecoder, loadPCLow, loadPCHigh, clearIrqEn, intDone;
  logic [2:0]  seqStep;
  logic [15:0] vecAddr;
  logic [1:0]  intCause;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [2:0]  step;
    logic [15:0] addr;
    logic        wr;
    logic [1:0]  cause;
    logic        lo;
    logic        hi;
    logic        done;
  } expT;

  expT sb[$];

  r88_int_seq dut (
    .sysClock      (sysClock),
    .sysResetN     (sysResetN),
    .resetReq      (resetReq),
    .nmiReq        (nmiReq),
    .irq           (irq),
    .irqEn         (irqEn),
    .instrBoundary (instrBoundary),
    .busAck        (busAck),
    .busReq        (busReq),
    .busWrite      (busWrite),
    .seqStep       (seqStep),
    .vecAddr       (vecAddr),
    .haltDecoder   (haltDecoder),
    .loadPCLow     (loadPCLow),
    .loadPCHigh    (loadPCHigh),
    .clearIrqEn    (clearIrqEn),
    .intDone       (intDone),
    .intCause      (intCause)
  );

  always #5 sysClock = ~sysClock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every completed bus step and every done pulse is matched against the queue.
  always @(negedge sysClock) begin
    if (sysResetN && ((busReq && busAck) || intDone)) begin
      checkCount++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_event: step=%0d addr=%h wr=%b cause=%0d done=%b with empty scoreboard",
                 seqStep, vecAddr, busWrite, intCause, intDone);
      end else begin
        expT e;
        e = sb.pop_front();
        if (seqStep === e.step && vecAddr === e.addr && busWrite === e.wr && intCause === e.cause &&
            loadPCLow === e.lo && loadPCHigh === e.hi && intDone === e.done && clearIrqEn === e.done)
          passCount++;
        else
          $display("FAIL bus_event: got step=%0d addr=%h wr=%b cause=%0d lo=%b hi=%b done=%b clr=%b expected step=%0d addr=%h wr=%b cause=%0d lo=%b hi=%b done=%b",
                   seqStep, vecAddr, busWrite, intCause, loadPCLow, loadPCHigh, intDone, clearIrqEn,
                   e.step, e.addr, e.wr, e.cause, e.lo, e.hi, e.done);
      end
    end
  end

  task automatic tick;
    @(posedge sysClock);
    #1;
  endtask

  task automatic pushExp(input logic [2:0] step, input logic [15:0] addr, input logic wr,
                         input logic [1:0] cause, input logic lo, input logic hi, input logic done);
    expT e;
    e.step = step; e.addr = addr; e.wr = wr; e.cause = cause; e.lo = lo; e.hi = hi; e.done = done;
    sb.push_back(e);
  endtask

  task automatic ackStep;
    int waited;
    waited = 0;
    while (!busReq && waited < 50) begin
      tick();
      waited++;
    end
    if (!busReq) begin
      checkCount++;
      $display("FAIL busreq_timeout: got busReq=0 expected busReq=1 within 50 cycles");
    end else begin
      busAck = 1'b1;
      tick();
      busAck = 1'b0;
    end
  endtask

  task automatic runPushes(input logic [1:0] cause);
    pushExp(3'd2, 16'h0000, 1'b1, cause, 1'b0, 1'b0, 1'b0); ackStep();
    pushExp(3'd3, 16'h0000, 1'b1, cause, 1'b0, 1'b0, 1'b0); ackStep();
    pushExp(3'd4, 16'h0000, 1'b1, cause, 1'b0, 1'b0, 1'b0); ackStep();
  endtask

  task automatic runVectors(input logic [1:0] cause, input logic [15:0] lo, input logic [15:0] hi);
    pushExp(3'd5, lo, 1'b0, cause, 1'b1, 1'b0, 1'b0); ackStep();
    pushExp(3'd6, hi, 1'b0, cause, 1'b0, 1'b1, 1'b0); ackStep();
    pushExp(3'd7, 16'h0000, 1'b0, cause, 1'b0, 1'b0, 1'b1);
    tick();
    chk("back_to_idle_step", {13'd0, seqStep}, 16'd0);
    chk("back_to_idle_cause", {14'd0, intCause}, 16'd0);
  endtask

  task automatic boundaryPulse;
    instrBoundary = 1'b1;
    tick();
    instrBoundary = 1'b0;
  endtask

  initial begin
    sysResetN = 1'b0; resetReq = 1'b0; nmiReq = 1'b0; irq = 1'b0; irqEn = 1'b0;
    instrBoundary = 1'b0; busAck = 1'b0;
    repeat (3) tick();
    chk("reset_step", {13'd0, seqStep}, 16'd1);
    chk("reset_cause", {14'd0, intCause}, 16'd1);
    chk("reset_outputs", {10'd0, busReq, busWrite, loadPCLow, loadPCHigh, intDone, clearIrqEn}, 16'd0);
    chk("reset_vecaddr", vecAddr, 16'h0000);
    chk("reset_halt", {15'd0, haltDecoder}, 16'd1);

    // Power-on: BOOT straight into the reset vector fetch.
    sysResetN = 1'b1;
    runVectors(2'd1, 16'hFFFC, 16'hFFFD);

    // Maskable IRQ taken at a boundary.
    irq = 1'b1; irqEn = 1'b1;
    boundaryPulse();
    irq = 1'b0;
    chk("irq_entry_halt", {15'd0, haltDecoder}, 16'd1);
    runPushes(2'd3);
    runVectors(2'd3, 16'hFFFE, 16'hFFFF);

    // Masked IRQ never starts a sequence.
    irq = 1'b1; irqEn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      boundaryPulse();
      chk("masked_irq_step", {13'd0, seqStep}, 16'd0);
      chk("masked_irq_busreq", {15'd0, busReq}, 16'd0);
    end

    // NMI edge and IRQ together: NMI first, IRQ at the next boundary after DONE.
    irqEn = 1'b1; nmiReq = 1'b1;
    tick();
    boundaryPulse();
    chk("nmi_cause", {14'd0, intCause}, 16'd2);
    runPushes(2'd2);
    runVectors(2'd2, 16'hFFFA, 16'hFFFB);
    tick();
    chk("no_entry_without_boundary", {13'd0, seqStep}, 16'd0);
    boundaryPulse();
    chk("irq_after_nmi_step", {13'd0, seqStep}, 16'd2);
    irq = 1'b0; nmiReq = 1'b0;
    runPushes(2'd3);
    runVectors(2'd3, 16'hFFFE, 16'hFFFF);

    // Soft reset during PUSH_PCL with a coincident ack, then a long-held VEC_LO.
    irq = 1'b1;
    boundaryPulse();
    irq = 1'b0;
    pushExp(3'd2, 16'h0000, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0); ackStep();
    chk("pre_reset_step", {13'd0, seqStep}, 16'd3);
    pushExp(3'd3, 16'h0000, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    resetReq = 1'b1; busAck = 1'b1;
    tick();
    resetReq = 1'b0; busAck = 1'b0;
    chk("softreset_step", {13'd0, seqStep}, 16'd5);
    chk("softreset_cause", {14'd0, intCause}, 16'd1);
    chk("softreset_vecaddr", vecAddr, 16'hFFFC);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_state", {13'd0, seqStep}, 16'd5);
      chk("hold_busreq_lo", {14'd0, busReq, loadPCLow}, 16'd2);
    end
    runVectors(2'd1, 16'hFFFC, 16'hFFFD);

    repeat (2) tick();
    chk("scoreboard_empty", sb.size(), 16'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/r88_int_seq.md
R88_INT_SEQ -- requirements
Module: r88_int_seq

Interface
REQ-001 SHALL have port: sysClock  in  1  sole clock, all state changes on its rising edge.
REQ-002 SHALL have port: sysResetN  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: resetReq in 1 soft-reset request (level); nmiReq in 1 NMI line, rising-edge sensitive; irq in 1 maskable interrupt request (level); irqEn in 1 decoder interrupt-enable flag.
REQ-004 SHALL have ports: instrBoundary in 1 decoder pulse, last cycle of an instruction; busAck in 1 one-cycle completion of the current bus step.
REQ-005 SHALL have outputs: busReq 1 bus step requested; busWrite 1 step is a stack push (0 = vector read); seqStep 3 current state code; vecAddr 16 vector byte address.
REQ-006 SHALL have outputs: haltDecoder 1 decoder frozen; loadPCLow 1 and loadPCHigh 1 latch intD into PC byte; clearIrqEn 1 and intDone 1 pulses; intCause 2 (0 none, 1 RESET, 2 NMI, 3 IRQ).

Function
REQ-007 SHALL implement states IDLE=0, BOOT=1, PUSH_PCH=2, PUSH_PCL=3, PUSH_FLG=4, VEC_LO=5, VEC_HI=6, DONE=7; seqStep equals the state code.
REQ-008 SHALL latch a nmiReq 0->1 transition (registered previous sample) into nmiPending, including during a running sequence.
REQ-009 SHALL clear nmiPending in the cycle an NMI sequence is entered; an edge in that same cycle SHALL re-set it.
REQ-010 SHALL, in IDLE with instrBoundary=1, select by priority resetReq > nmiPending > (irq & irqEn); with none asserted SHALL remain IDLE.
REQ-011 SHALL, from IDLE, go to VEC_LO for RESET and to PUSH_PCH for NMI/IRQ, loading intCause in the same cycle.
REQ-012 SHALL assert resetReq from any state, regardless of instrBoundary, forcing next state VEC_LO, intCause=RESET and clearing nmiPending; a coincident busAck SHALL be ignored.
REQ-013 SHALL assert busReq in PUSH_PCH, PUSH_PCL, PUSH_FLG, VEC_LO and VEC_HI, and hold state until busAck=1, then advance in order PUSH_PCH->PUSH_PCL->PUSH_FLG->VEC_LO->VEC_HI->DONE.
REQ-014 SHALL drive busWrite=1 only in the PUSH states.
REQ-015 SHALL drive vecAddr low byte as NMI 0xFFFA, RESET 0xFFFC, IRQ 0xFFFE in VEC_LO, and +1 in VEC_HI; 0x0000 otherwise.
REQ-016 SHALL pulse loadPCLow with busAck in VEC_LO and loadPCHigh with busAck in VEC_HI (combinational with busAck).
REQ-017 SHALL, in DONE, pulse intDone and clearIrqEn for exactly one cycle (clearIrqEn for all causes), then return to IDLE with intCause=0.
REQ-018 SHALL assert haltDecoder in every state except IDLE.
REQ-019 SHALL enter no new sequence in DONE, even if requests are pending; arbitration resumes at the next instrBoundary in IDLE.
REQ-020 SHALL have unbounded busAck wait; busAck in IDLE, BOOT or DONE SHALL be ignored.

Reset
REQ-021 SHALL, while sysResetN=0: state=BOOT, nmiPending=0, nmi sample=0, intCause=RESET, all pulse outputs and busReq/busWrite=0, vecAddr=0, haltDecoder=1.
REQ-022 SHALL leave BOOT for VEC_LO in the first clock edge after sysResetN rises, performing a full reset-vector fetch without pushes.

Structure
REQ-023 SHALL take state codes, intCause encodings and the three vector addresses from shared package r88_pkg, also used by the decoder.
REQ-024 SHALL be one module; the NMI edge detector MAY be sub-module r88_edge_det.

Verification
REQ-025 SHALL cover: release sysResetN -> BOOT, VEC_LO addr 0xFFFC, VEC_HI 0xFFFD, loadPCLow/loadPCHigh on acks, intDone one cycle, IDLE.
REQ-026 SHALL cover: irq=1, irqEn=1, instrBoundary pulse -> steps 2,3,4 with busWrite=1, then vector 0xFFFE/0xFFFF, intCause=3, clearIrqEn pulse.
REQ-027 SHALL cover: irq=1, irqEn=0, 10 boundaries -> stays IDLE, busReq never 1.
REQ-028 SHALL cover: nmiReq edge plus irq in same cycle -> NMI first (0xFFFA); IRQ taken at the next boundary after DONE.
REQ-029 SHALL cover: resetReq=1 during PUSH_PCL with busAck=1 -> next state VEC_LO, intCause=1, vecAddr 0xFFFC, no PUSH_FLG.
REQ-030 SHALL cover: busAck withheld 20 cycles in VEC_LO -> state and busReq held, single loadPCLow at ack.
